// File: rtl/rotate_controller_pkg.sv
// Shared definitions for piece rotation: geometry constants, block type codes,
// the rotation map and the rotate sequencer state encoding.
package rotate_controller_pkg;

  localparam int unsigned SIZE     = 16;
  localparam int unsigned FIELD_X0 = 240;
  localparam int unsigned FIELD_X1 = 400;
  localparam int unsigned FIELD_W  = 10;

  typedef enum logic [3:0] {
    SQUARE  = 4'd0,
    BAR_H   = 4'd1,
    BAR_V   = 4'd2,
    T_UP    = 4'd3,
    T_RIGHT = 4'd4,
    T_DOWN  = 4'd5,
    T_LEFT  = 4'd6,
    Z_HORIZ = 4'd7,
    Z_VERT  = 4'd8,
    S_HORIZ = 4'd9,
    S_VERT  = 4'd10
  } block_type_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PROBE  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAIL   = 3'd4
  } rot_state_e;

  // Returns {valid, rotated_type}; codes 11..15 are not pieces and come back invalid.
  function automatic logic [4:0] rotate_map(input logic [3:0] t);
    logic [4:0] r_s;
    case (t)
      4'd0:    r_s = {1'b1, 4'd0};
      4'd1:    r_s = {1'b1, 4'd2};
      4'd2:    r_s = {1'b1, 4'd1};
      4'd3:    r_s = {1'b1, 4'd4};
      4'd4:    r_s = {1'b1, 4'd5};
      4'd5:    r_s = {1'b1, 4'd6};
      4'd6:    r_s = {1'b1, 4'd3};
      4'd7:    r_s = {1'b1, 4'd8};
      4'd8:    r_s = {1'b1, 4'd7};
      4'd9:    r_s = {1'b1, 4'd10};
      4'd10:   r_s = {1'b1, 4'd9};
      default: r_s = {1'b0, 4'd0};
    endcase
    return r_s;
  endfunction

endpackage

// File: rtl/rotate_controller_next_type.sv
// Combinational lookup of the type a piece becomes after one clockwise rotation.
module rotate_next_type
  import rotate_controller_pkg::*;
(
  input  logic [3:0] cur_type,
  output logic [3:0] next_type,
  output logic       valid
);

  logic [4:0] map_s;

  // Decode the rotation map into type and validity.
  always_comb begin
    map_s     = rotate_map(cur_type);
    next_type = map_s[3:0];
    valid     = map_s[4];
  end

endmodule

// File: rtl/rotate_controller.sv
// Rotation sequencer: accepts a rotate request, presents the centre candidate and
// optional one-cell wall kicks to the shared collision checker, and commits the
// first candidate that does not collide.
module rotate_controller
  import rotate_controller_pkg::*;
#(
  parameter int unsigned SIZE     = rotate_controller_pkg::SIZE,
  parameter int unsigned FIELD_X0 = rotate_controller_pkg::FIELD_X0,
  parameter int unsigned FIELD_X1 = rotate_controller_pkg::FIELD_X1,
  parameter int unsigned FIELD_W  = rotate_controller_pkg::FIELD_W,
  parameter bit          KICK_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rot_req,
  input  logic       cancel,
  input  logic [3:0] cur_type,
  input  logic [9:0] cur_x,
  input  logic [9:0] cur_y,
  input  logic       chk_stop,
  output logic [3:0] chk_type,
  output logic [9:0] chk_x,
  output logic [9:0] chk_y,
  output logic [9:0] chk_grid,
  output logic       rot_busy,
  output logic       rot_done,
  output logic       rot_fail,
  output logic [3:0] new_type,
  output logic [9:0] new_x
);

  rot_state_e state_r, state_nxt_s;
  logic [1:0] attempt_r, attempt_nxt_s;
  logic [9:0] base_x_r, base_x_nxt_s;

  logic [3:0] chk_type_r, chk_type_nxt_s;
  logic [9:0] chk_x_r, chk_x_nxt_s;
  logic [9:0] chk_y_r, chk_y_nxt_s;
  logic [9:0] chk_grid_r, chk_grid_nxt_s;
  logic       rot_busy_r, rot_busy_nxt_s;
  logic       rot_done_r, rot_done_nxt_s;
  logic       rot_fail_r, rot_fail_nxt_s;
  logic [3:0] new_type_r, new_type_nxt_s;
  logic [9:0] new_x_r, new_x_nxt_s;

  logic [3:0] rot_type_s;
  logic       rot_valid_s;
  logic       left_ok_s, right_ok_s;
  logic [9:0] left_x_s, right_x_s;
  logic [9:0] grid_x_s, grid_y_s, grid_s;

  // Grid cell index of a candidate reference point; divisions by a power-of-two SIZE reduce to shifts.
  function automatic logic [9:0] grid_of(input logic [9:0] x, input logic [9:0] y);
    logic [9:0] row_s;
    logic [9:0] col_s;
    row_s = y / 10'(SIZE);
    col_s = (x - 10'(FIELD_X0)) / 10'(SIZE);
    return (row_s * 10'(FIELD_W)) + col_s;
  endfunction

  rotate_next_type u_next_type (
    .cur_type  (cur_type),
    .next_type (rot_type_s),
    .valid     (rot_valid_s)
  );

  // Kick legality is judged from the latched x so input changes mid-rotation are ignored.
  always_comb begin
    left_x_s   = base_x_r - 10'(SIZE);
    right_x_s  = base_x_r + 10'(SIZE);
    left_ok_s  = KICK_EN && ({1'b0, base_x_r} >= 11'(FIELD_X0 + SIZE));
    right_ok_s = KICK_EN && (({1'b0, base_x_r} + 11'(SIZE)) <= 11'(FIELD_X1 - SIZE));
    grid_s     = grid_of(grid_x_s, grid_y_s);
  end

  // Next-state and next-output decode; every register holds unless a transition updates it.
  always_comb begin
    state_nxt_s    = state_r;
    attempt_nxt_s  = attempt_r;
    base_x_nxt_s   = base_x_r;
    chk_type_nxt_s = chk_type_r;
    chk_x_nxt_s    = chk_x_r;
    chk_y_nxt_s    = chk_y_r;
    chk_grid_nxt_s = chk_grid_r;
    new_type_nxt_s = new_type_r;
    new_x_nxt_s    = new_x_r;
    rot_done_nxt_s = 1'b0;
    rot_fail_nxt_s = 1'b0;
    grid_x_s       = cur_x;
    grid_y_s       = cur_y;

    case (state_r)
      ST_IDLE: begin
        if (rot_req && !cancel) begin
          base_x_nxt_s  = cur_x;
          attempt_nxt_s = 2'd0;
          if (cur_type == SQUARE) begin
            state_nxt_s    = ST_DONE;
            rot_done_nxt_s = 1'b1;
            new_type_nxt_s = rot_type_s;
            new_x_nxt_s    = cur_x;
          end else if (!rot_valid_s) begin
            state_nxt_s    = ST_FAIL;
            rot_fail_nxt_s = 1'b1;
          end else begin
            state_nxt_s    = ST_PROBE;
            chk_type_nxt_s = rot_type_s;
            chk_x_nxt_s    = cur_x;
            chk_y_nxt_s    = cur_y;
            chk_grid_nxt_s = grid_s;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PROBE: begin
        if (cancel) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        grid_y_s = chk_y_r;
        if ((attempt_r == 2'd0) && left_ok_s) begin
          grid_x_s = left_x_s;
        end else begin
          grid_x_s = right_x_s;
        end
        if (cancel) begin
          state_nxt_s = ST_IDLE;
        end else if (!chk_stop) begin
          state_nxt_s    = ST_DONE;
          rot_done_nxt_s = 1'b1;
          new_type_nxt_s = chk_type_r;
          new_x_nxt_s    = chk_x_r;
        end else if ((attempt_r == 2'd0) && left_ok_s) begin
          state_nxt_s    = ST_PROBE;
          attempt_nxt_s  = 2'd1;
          chk_x_nxt_s    = left_x_s;
          chk_grid_nxt_s = grid_s;
        end else if ((attempt_r != 2'd2) && right_ok_s) begin
          state_nxt_s    = ST_PROBE;
          attempt_nxt_s  = 2'd2;
          chk_x_nxt_s    = right_x_s;
          chk_grid_nxt_s = grid_s;
        end else begin
          state_nxt_s    = ST_FAIL;
          rot_fail_nxt_s = 1'b1;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      ST_FAIL: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase

    rot_busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State and output registers; reset clears everything and overrides all other inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      attempt_r  <= 2'd0;
      base_x_r   <= 10'd0;
      chk_type_r <= 4'd0;
      chk_x_r    <= 10'd0;
      chk_y_r    <= 10'd0;
      chk_grid_r <= 10'd0;
      rot_busy_r <= 1'b0;
      rot_done_r <= 1'b0;
      rot_fail_r <= 1'b0;
      new_type_r <= 4'd0;
      new_x_r    <= 10'd0;
    end else begin
      state_r    <= state_nxt_s;
      attempt_r  <= attempt_nxt_s;
      base_x_r   <= base_x_nxt_s;
      chk_type_r <= chk_type_nxt_s;
      chk_x_r    <= chk_x_nxt_s;
      chk_y_r    <= chk_y_nxt_s;
      chk_grid_r <= chk_grid_nxt_s;
      rot_busy_r <= rot_busy_nxt_s;
      rot_done_r <= rot_done_nxt_s;
      rot_fail_r <= rot_fail_nxt_s;
      new_type_r <= new_type_nxt_s;
      new_x_r    <= new_x_nxt_s;
    end
  end

  assign chk_type = chk_type_r;
  assign chk_x    = chk_x_r;
  assign chk_y    = chk_y_r;
  assign chk_grid = chk_grid_r;
  assign rot_busy = rot_busy_r;
  assign rot_done = rot_done_r;
  assign rot_fail = rot_fail_r;
  assign new_type = new_type_r;
  assign new_x    = new_x_r;

endmodule

// File: tb/tb_rotate_controller.sv
// Scoreboard bench for rotate_controller: randomized rotate requests, expected
// outcome computed from the rotation rules, compared by an independent monitor.
module tb_rotate_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rot_req = 1'b0;
  logic       cancel = 1'b0;
  logic [3:0] cur_type = 4'd0;
  logic [9:0] cur_x = 10'd0;
  logic [9:0] cur_y = 10'd0;
  logic       chk_stop;
  logic [3:0] chk_type;
  logic [9:0] chk_x, chk_y, chk_grid;
  logic       rot_busy, rot_done, rot_fail;
  logic [3:0] new_type;
  logic [9:0] new_x;

  // Collision responder: stop bit per candidate (centre, left kick, right kick).
  logic [9:0] base_x = 10'd0;
  logic [2:0] pat = 3'b000;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit is_done;
    int ntype;
    int nx;
    int lat;
    int cx;
    int ctype;
    int cgrid;
    int req_cyc;
  } exp_t;
  exp_t sb_q[$];

  // Reference state: last candidate shown to the checker, last committed result.
  int m_chk_x = 0, m_chk_type = 0, m_chk_grid = 0, m_new_x = 0, m_new_type = 0;
  int rot_tab[11] = '{0, 2, 1, 4, 5, 6, 3, 8, 7, 10, 9};

  rotate_controller dut (
    .clk(clk), .rst(rst), .rot_req(rot_req), .cancel(cancel),
    .cur_type(cur_type), .cur_x(cur_x), .cur_y(cur_y), .chk_stop(chk_stop),
    .chk_type(chk_type), .chk_x(chk_x), .chk_y(chk_y), .chk_grid(chk_grid),
    .rot_busy(rot_busy), .rot_done(rot_done), .rot_fail(rot_fail),
    .new_type(new_type), .new_x(new_x)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    if (chk_x == base_x) chk_stop = pat[0];
    else if (chk_x == base_x - 10'd16) chk_stop = pat[1];
    else chk_stop = pat[2];
  end

  function automatic int grid(input int x, input int y);
    int dx;
    dx = (x - 240) & 1023;
    return ((y / 16) * 10 + dx / 16) % 1024;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done/fail pulse must match the oldest expected outcome.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (rot_done || rot_fail)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: done=%0b fail=%0b with nothing pending (cycle %0d)", rot_done, rot_fail, cyc);
      end else begin
        e = sb_q.pop_front();
        check("pulse_is_done", int'(rot_done), int'(e.is_done));
        check("pulse_is_fail", int'(rot_fail), int'(!e.is_done));
        check("latency", cyc - e.req_cyc, e.lat);
        check("new_type", int'(new_type), e.ntype);
        check("new_x", int'(new_x), e.nx);
        check("chk_x", int'(chk_x), e.cx);
        check("chk_type", int'(chk_type), e.ctype);
        check("chk_grid", int'(chk_grid), e.cgrid);
      end
    end
  end

  // Compute the expected outcome from the rotation rules, then issue the request.
  task automatic issue(input int t, input int x, input int y, input bit [2:0] p);
    exp_t e;
    int xs[$];
    int ks[$];
    int k;
    e.is_done = 1'b0;
    e.lat = 1;
    if (t > 10) begin
      e.is_done = 1'b0;
    end else if (t == 0) begin
      e.is_done = 1'b1;
      m_new_type = 0;
      m_new_x = x;
    end else begin
      xs.push_back(x); ks.push_back(0);
      if (x >= 240 + 16) begin xs.push_back(x - 16); ks.push_back(1); end
      if (x + 16 <= 400 - 16) begin xs.push_back(x + 16); ks.push_back(2); end
      k = -1;
      for (int i = 0; i < xs.size(); i++) begin
        if (k < 0 && !p[ks[i]]) k = i;
      end
      m_chk_type = rot_tab[t];
      if (k >= 0) begin
        e.is_done = 1'b1;
        e.lat = 3 + 2 * k;
        m_chk_x = xs[k];
        m_new_type = rot_tab[t];
        m_new_x = xs[k];
      end else begin
        e.lat = 1 + 2 * xs.size();
        m_chk_x = xs[xs.size() - 1];
      end
      m_chk_grid = grid(m_chk_x, y);
    end
    e.ntype = m_new_type; e.nx = m_new_x;
    e.cx = m_chk_x; e.ctype = m_chk_type; e.cgrid = m_chk_grid;

    @(posedge clk); #1;
    base_x = 10'(x); pat = p;
    cur_type = 4'(t); cur_x = 10'(x); cur_y = 10'(y);
    rot_req = 1'b1;
    e.req_cyc = cyc;
    sb_q.push_back(e);
    @(posedge clk); #1;
    check("busy_after_accept", int'(rot_busy), 1);
    // Spurious request and input churn while busy must be ignored.
    rot_req = 1'($urandom % 2);
    cur_type = 4'($urandom_range(10, 0));
    cur_x = 10'($urandom_range(400, 240));
    cur_y = 10'($urandom_range(300, 0));
    @(posedge clk); #1;
    rot_req = 1'b0;
    wait_drain();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d outcomes still pending after %0d cycles", sb_q.size(), n);
      sb_q.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_chk_type"}, int'(chk_type), 0);
    check({tag, "_chk_x"}, int'(chk_x), 0);
    check({tag, "_chk_y"}, int'(chk_y), 0);
    check({tag, "_chk_grid"}, int'(chk_grid), 0);
    check({tag, "_busy"}, int'(rot_busy), 0);
    check({tag, "_done"}, int'(rot_done), 0);
    check({tag, "_fail"}, int'(rot_fail), 0);
    check({tag, "_new_type"}, int'(new_type), 0);
    check({tag, "_new_x"}, int'(new_x), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Directed scenarios.
    issue(3, 304, 160, 3'b000);
    issue(1, 368, 32, 3'b001);
    issue(7, 240, 64, 3'b111);
    issue(0, 280, 48, 3'b111);
    issue(12, 300, 48, 3'b000);
    issue(5, 392, 80, 3'b101);
    issue(9, 300, 96, 3'b011);

    // Cancel during SAMPLE: no pulse, committed result unchanged.
    @(posedge clk); #1;
    base_x = 10'd300; pat = 3'b111;
    cur_type = 4'd3; cur_x = 10'd300; cur_y = 10'd100;
    rot_req = 1'b1;
    @(posedge clk); #1;
    rot_req = 1'b0;
    @(posedge clk); #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cancel_busy", int'(rot_busy), 0);
    check("cancel_new_type", int'(new_type), m_new_type);
    check("cancel_new_x", int'(new_x), m_new_x);
    m_chk_type = 4; m_chk_x = 300; m_chk_grid = grid(300, 100);
    repeat (8) @(posedge clk);
    #1;
    check("cancel_chk_x", int'(chk_x), m_chk_x);

    // Request and cancel together in IDLE: not accepted.
    rot_req = 1'b1; cancel = 1'b1; cur_type = 4'd1;
    @(posedge clk); #1;
    rot_req = 1'b0; cancel = 1'b0;
    check("req_cancel_busy", int'(rot_busy), 0);
    repeat (4) @(posedge clk);

    // Reset while in PROBE.
    #1;
    base_x = 10'd320; pat = 3'b000;
    cur_type = 4'd7; cur_x = 10'd320; cur_y = 10'd64;
    rot_req = 1'b1;
    @(posedge clk); #1;
    rot_req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("mid_reset");
    rst = 1'b0;
    m_chk_x = 0; m_chk_type = 0; m_chk_grid = 0; m_new_x = 0; m_new_type = 0;
    repeat (6) @(posedge clk);
    issue(3, 304, 160, 3'b000);

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      int t;
      if ($urandom_range(4, 0) == 0) t = int'($urandom_range(15, 0));
      else t = int'($urandom_range(10, 0));
      issue(t, int'($urandom_range(420, 224)), int'($urandom_range(300, 0)), 3'($urandom_range(7, 0)));
    end

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
